// File: rtl/vga_pkg.sv
// Shared VGA raster types and default 640x480@60 timing.
// Totals are computed by helper functions so both axes size themselves the same way.
package vga_pkg;

  typedef enum logic [1:0] {
    ACTIVO,
    PORCHE_DEL,
    SINCRONIA,
    PORCHE_TRAS
  } estado_eje_t;

  localparam int EJE_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  function automatic int h_total(input int a, input int fp, input int s, input int bp);
    return a + fp + s + bp;
  endfunction

  function automatic int v_total(input int a, input int fp, input int s, input int bp);
    return a + fp + s + bp;
  endfunction

endpackage

// File: rtl/eje_sincronia_vga.sv
// One raster axis: segment FSM with a down-counter per segment, plus an absolute
// position counter and a flag marking the last position of the axis.
module eje_sincronia_vga
  import vga_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             avanzar_i,
  output logic [1:0]       estado_o,
  output logic [EJE_W-1:0] pos_o,
  output logic             ultimo_o
);

  localparam logic [EJE_W-1:0] L_ACT   = EJE_W'(ACTIVE - 1);
  localparam logic [EJE_W-1:0] L_FP    = EJE_W'(FP - 1);
  localparam logic [EJE_W-1:0] L_SYNC  = EJE_W'(SYNC - 1);
  localparam logic [EJE_W-1:0] L_BP    = EJE_W'(BP - 1);
  localparam logic [EJE_W-1:0] L_TOTAL = EJE_W'(h_total(ACTIVE, FP, SYNC, BP) - 1);

  estado_eje_t      estado_q, estado_d;
  logic [EJE_W-1:0] seg_q, seg_d;
  logic [EJE_W-1:0] pos_q, pos_d;

  assign ultimo_o = (pos_q == L_TOTAL);
  assign estado_o = estado_q;
  assign pos_o    = pos_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      estado_q <= ACTIVO;
      seg_q    <= L_ACT;
      pos_q    <= '0;
    end else begin
      estado_q <= estado_d;
      seg_q    <= seg_d;
      pos_q    <= pos_d;
    end
  end

  // The segment counter reloads with the length of the segment being entered.
  always_comb begin
    estado_d = estado_q;
    seg_d    = seg_q;
    pos_d    = pos_q;
    if (avanzar_i) begin
      pos_d = ultimo_o ? '0 : pos_q + 1'b1;
      if (seg_q == '0) begin
        unique case (estado_q)
          ACTIVO:      begin estado_d = PORCHE_DEL;  seg_d = L_FP;   end
          PORCHE_DEL:  begin estado_d = SINCRONIA;   seg_d = L_SYNC; end
          SINCRONIA:   begin estado_d = PORCHE_TRAS; seg_d = L_BP;   end
          PORCHE_TRAS: begin estado_d = ACTIVO;      seg_d = L_ACT;  end
        endcase
      end else begin
        seg_d = seg_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/controlador_sincronia_vga.sv
// VGA raster timing: H and V axis FSMs drive registered sync, blanking, coordinates and strobes.
// Define VGA_DIVISOR_PIXEL_EN to derive the pixel tick from every second reloj cycle.
module controlador_sincronia_vga
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       reloj,
  input  logic       reset,
  input  logic       habilitar,
  output logic       hsync,
  output logic       vsync,
  output logic       video_activo,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       fin_linea,
  output logic       fin_cuadro
);

  if (h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) > 1024 ||
      v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) > 1024) begin : g_chk_totales
    $error("controlador_sincronia_vga: raster totals exceed 10-bit counters");
  end

  logic tick;

`ifdef VGA_DIVISOR_PIXEL_EN
  logic div_q;

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) div_q <= 1'b0;
    else       div_q <= ~div_q;
  end

  assign tick = habilitar & div_q;
`else
  assign tick = habilitar;
`endif

  logic [1:0]       h_est, v_est;
  logic [EJE_W-1:0] h_pos, v_pos;
  logic             h_ult, v_ult;

  eje_sincronia_vga #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_eje_h (
    .clk_i(reloj), .rst_i(reset), .avanzar_i(tick),
    .estado_o(h_est), .pos_o(h_pos), .ultimo_o(h_ult)
  );

  eje_sincronia_vga #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_eje_v (
    .clk_i(reloj), .rst_i(reset), .avanzar_i(h_ult & tick),
    .estado_o(v_est), .pos_o(v_pos), .ultimo_o(v_ult)
  );

  logic       hsync_q, hsync_d, vsync_q, vsync_d, video_q, video_d;
  logic [9:0] px_q, px_d, py_q, py_d;
  logic       fl_q, fl_d, fc_q, fc_d;

  // Position and sync only move on ticks, so a disabled raster shows the held position.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    video_d = video_q;
    px_d    = px_q;
    py_d    = py_q;
    fl_d    = tick & h_ult;
    fc_d    = tick & h_ult & v_ult;
    if (tick) begin
      hsync_d = (h_est == SINCRONIA) ? SYNC_POL : ~SYNC_POL;
      vsync_d = (v_est == SINCRONIA) ? SYNC_POL : ~SYNC_POL;
      video_d = (h_est == ACTIVO) && (v_est == ACTIVO);
      px_d    = h_pos;
      py_d    = v_pos;
    end else if (!habilitar) begin
      video_d = 1'b0;
    end
  end

  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      video_q <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      fl_q    <= 1'b0;
      fc_q    <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
      px_q    <= px_d;
      py_q    <= py_d;
      fl_q    <= fl_d;
      fc_q    <= fc_d;
    end
  end

  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_activo = video_q;
  assign pixel_x      = px_q;
  assign pixel_y      = py_q;
  assign fin_linea    = fl_q;
  assign fin_cuadro   = fc_q;

endmodule

// File: tb/tb_controlador_sincronia_vga.sv
// Directed bench: full-size raster for line/freeze/async-reset checks, and a small
// active-high-sync raster for whole-frame checks within a short run.
module tb_controlador_sincronia_vga;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, hab_a, hs_a, vs_a, va_a, fl_a, fc_a;
  logic [9:0] px_a, py_a;
  logic       rst_b, hab_b, hs_b, vs_b, va_b, fl_b, fc_b;
  logic [9:0] px_b, py_b;

  controlador_sincronia_vga dut_a (
    .reloj(clk), .reset(rst_a), .habilitar(hab_a),
    .hsync(hs_a), .vsync(vs_a), .video_activo(va_a),
    .pixel_x(px_a), .pixel_y(py_a), .fin_linea(fl_a), .fin_cuadro(fc_a)
  );

  controlador_sincronia_vga #(
    .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1)
  ) dut_b (
    .reloj(clk), .reset(rst_b), .habilitar(hab_b),
    .hsync(hs_b), .vsync(vs_b), .video_activo(va_b),
    .pixel_x(px_b), .pixel_y(py_b), .fin_linea(fl_b), .fin_cuadro(fc_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a(input string tag, input int x, input int y, input int lim);
    int k = 0;
    while (!(px_a == 10'(x) && py_a == 10'(y)) && k < lim) begin
      tick();
      k++;
    end
    check_val(tag, {31'd0, (px_a == 10'(x) && py_a == 10'(y))}, 32'd1);
  endtask

  initial begin
    int x_bad, hs_bad, hs_low, fl_cnt, fl_x, fc_cnt, frz_bad;
    int va_cnt, va_bad, vs_bad, vs_hi, hb_bad, fcb_cnt, fcb_x, fcb_y, flb_cnt;
    logic exp_s;

    rst_a = 1'b1; hab_a = 1'b1;
    rst_b = 1'b1; hab_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_hsync", 32'(hs_a), 32'd1);
    check_val("rst_vsync", 32'(vs_a), 32'd1);
    check_val("rst_video", 32'(va_a), 32'd0);
    check_val("rst_px",    32'(px_a), 32'd0);
    check_val("rst_py",    32'(py_a), 32'd0);
    check_val("rst_strb",  32'({fl_a, fc_a}), 32'd0);
    check_val("rst_b_sync_pol", 32'({hs_b, vs_b}), 32'd0);

    rst_a = 1'b0;
    tick();
    check_val("first_video", 32'(va_a), 32'd1);
    check_val("first_px", 32'(px_a), 32'd0);
    check_val("first_py", 32'(py_a), 32'd0);

    // One full line on the default raster.
    x_bad = 0; hs_bad = 0; hs_low = 0; fl_cnt = 0; fl_x = -1; fc_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) tick();
      if (px_a != 10'(i)) x_bad++;
      exp_s = !(i >= 656 && i <= 751);
      if (hs_a !== exp_s) hs_bad++;
      if (hs_a == 1'b0) hs_low++;
      if (fl_a) begin fl_cnt++; fl_x = int'(px_a); end
      if (fc_a) fc_cnt++;
    end
    check_val("line_px_seq", 32'(x_bad), 32'd0);
    check_val("line_hsync_shape", 32'(hs_bad), 32'd0);
    check_val("line_hsync_width", 32'(hs_low), 32'd96);
    check_val("line_fin_cnt", 32'(fl_cnt), 32'd1);
    check_val("line_fin_x", 32'(fl_x), 32'd799);
    check_val("line_no_fc", 32'(fc_cnt), 32'd0);
    tick();
    check_val("wrap_px", 32'(px_a), 32'd0);
    check_val("wrap_py", 32'(py_a), 32'd1);

    // Freeze at (100,10) for 37 clocks.
    wait_a("reach_100_10", 100, 10, 10000);
    check_val("pre_frz_video", 32'(va_a), 32'd1);
    hab_a = 1'b0;
    frz_bad = 0;
    for (int i = 0; i < 37; i++) begin
      tick();
      if (px_a != 10'd100 || py_a != 10'd10 || va_a !== 1'b0 || fl_a !== 1'b0) frz_bad++;
    end
    check_val("freeze_hold", 32'(frz_bad), 32'd0);
    check_val("freeze_hsync", 32'(hs_a), 32'd1);
    hab_a = 1'b1;
    tick();
    check_val("resume_px", 32'(px_a), 32'd101);
    check_val("resume_py", 32'(py_a), 32'd10);
    check_val("resume_video", 32'(va_a), 32'd1);

    // Asynchronous reset while hsync is asserted.
    wait_a("reach_700_10", 700, 10, 2000);
    check_val("pre_rst_hsync", 32'(hs_a), 32'd0);
    #2 rst_a = 1'b1;
    #1;
    check_val("arst_px", 32'(px_a), 32'd0);
    check_val("arst_py", 32'(py_a), 32'd0);
    check_val("arst_hsync", 32'(hs_a), 32'd1);
    check_val("arst_video", 32'(va_a), 32'd0);

    // Whole frame on the small raster: 19 x 12, active 10 x 6, sync active-high.
    rst_b = 1'b0;
    x_bad = 0; va_cnt = 0; va_bad = 0; vs_bad = 0; vs_hi = 0; hb_bad = 0;
    fcb_cnt = 0; fcb_x = -1; fcb_y = -1; flb_cnt = 0;
    for (int i = 0; i < 228; i++) begin
      int x, y;
      x = i % 19;
      y = i / 19;
      tick();
      if (px_b != 10'(x) || py_b != 10'(y)) x_bad++;
      if (va_b !== (x < 10 && y < 6)) va_bad++;
      if (va_b) va_cnt++;
      if (hs_b !== (x >= 12 && x <= 14)) hb_bad++;
      if (vs_b !== (y >= 7 && y <= 8)) vs_bad++;
      if (vs_b) vs_hi++;
      if (fl_b) flb_cnt++;
      if (fc_b) begin fcb_cnt++; fcb_x = int'(px_b); fcb_y = int'(py_b); end
    end
    check_val("frm_pos_seq", 32'(x_bad), 32'd0);
    check_val("frm_video_shape", 32'(va_bad), 32'd0);
    check_val("frm_video_cnt", 32'(va_cnt), 32'd60);
    check_val("frm_hsync_shape", 32'(hb_bad), 32'd0);
    check_val("frm_vsync_shape", 32'(vs_bad), 32'd0);
    check_val("frm_vsync_clks", 32'(vs_hi), 32'd38);
    check_val("frm_fin_linea_cnt", 32'(flb_cnt), 32'd12);
    check_val("frm_fc_cnt", 32'(fcb_cnt), 32'd1);
    check_val("frm_fc_x", 32'(fcb_x), 32'd18);
    check_val("frm_fc_y", 32'(fcb_y), 32'd11);
    tick();
    check_val("frm_wrap_px", 32'(px_b), 32'd0);
    check_val("frm_wrap_py", 32'(py_b), 32'd0);
    check_val("frm_wrap_video", 32'(va_b), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
